// File: rtl/thunderbird_main_if.sv
// Lamp-controller bus: driver requests in, six lamp drives and the fault flag out.
interface thunderbird_main_if;
    logic brake;
    logic left;
    logic right;
    logic l0;
    logic l1;
    logic l2;
    logic r0;
    logic r1;
    logic r2;
    logic error;

    // Switch side: drives requests, observes lamps.
    modport master (
        output brake,
        output left,
        output right,
        input  l0,
        input  l1,
        input  l2,
        input  r0,
        input  r1,
        input  r2,
        input  error
    );

    // Lamp controller side.
    modport slave (
        input  brake,
        input  left,
        input  right,
        output l0,
        output l1,
        output l2,
        output r0,
        output r1,
        output r2,
        output error
    );
endinterface

// File: rtl/thunderbird_main.sv
// Thunderbird tail-light sequencer: three-lamp inner-to-outer turn sweep per side,
// brake on the non-turning side, sticky fault when left and right are requested together.
// Outputs are decoded from registers only, so no request reaches a lamp combinationally.
module thunderbird_main (
    input  logic                 clka,
    input  logic                 restart,
    thunderbird_main_if.slave    bus
);

    localparam logic [1:0] DIR_NONE  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;

    logic [1:0] r_phase;
    logic [1:0] r_dir;
    logic       r_err;
    logic       r_brake_q;

    logic [1:0] w_phase_nxt;
    logic [1:0] w_dir_nxt;
    logic       w_err_nxt;
    logic       w_both;

    logic [2:0] w_pattern;
    logic [2:0] w_left_lamps;
    logic [2:0] w_right_lamps;

    // Sweep pattern, lamp 0 innermost: dark, then one, two, three lamps lit.
    function automatic logic [2:0] sweep_pattern(input logic [1:0] phase);
        logic [2:0] pat;
        case (phase)
            2'd1:    pat = 3'b001;
            2'd2:    pat = 3'b011;
            2'd3:    pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    assign w_both = bus.left & bus.right;

    // Next-state rules: fault dominates; a new side restarts the sweep at phase 1.
    always_comb begin
        w_phase_nxt = 2'd0;
        w_dir_nxt   = DIR_NONE;
        w_err_nxt   = r_err;
        if (r_err || w_both) begin
            w_err_nxt = 1'b1;
        end else if (bus.left) begin
            w_dir_nxt   = DIR_LEFT;
            w_phase_nxt = (r_dir == DIR_LEFT) ? r_phase + 2'd1 : 2'd1;
        end else if (bus.right) begin
            w_dir_nxt   = DIR_RIGHT;
            w_phase_nxt = (r_dir == DIR_RIGHT) ? r_phase + 2'd1 : 2'd1;
        end
    end

    // State registers; restart clears everything, including the sticky fault.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            r_phase   <= 2'd0;
            r_dir     <= DIR_NONE;
            r_err     <= 1'b0;
            r_brake_q <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_dir     <= w_dir_nxt;
            r_err     <= w_err_nxt;
            r_brake_q <= bus.brake;
        end
    end

    assign w_pattern = sweep_pattern(r_phase);

    // Lamp decode: turning side shows the sweep, every other lamp shows the registered brake.
    always_comb begin
        w_left_lamps  = {3{r_brake_q}};
        w_right_lamps = {3{r_brake_q}};
        case (r_dir)
            DIR_LEFT:  w_left_lamps  = w_pattern;
            DIR_RIGHT: w_right_lamps = w_pattern;
            default:   ;
        endcase
    end

    assign bus.l0    = w_left_lamps[0];
    assign bus.l1    = w_left_lamps[1];
    assign bus.l2    = w_left_lamps[2];
    assign bus.r0    = w_right_lamps[0];
    assign bus.r1    = w_right_lamps[1];
    assign bus.r2    = w_right_lamps[2];
    assign bus.error = r_err;

endmodule

// File: tb/tb_thunderbird_main.sv
// Bench for thunderbird_main: directed test-plan steps followed by randomized
// request sequences, checked against a run-length model of the lamp behaviour.
module tb_thunderbird_main;

    logic clka = 1'b0;
    logic restart;

    thunderbird_main_if bus ();

    thunderbird_main dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clka = ~clka;

    int n_vec = 0;
    int n_bad = 0;

    // Model: side 0=none 1=left 2=right; run = consecutive edges the side has been held.
    int m_side;
    int m_run;
    bit m_err;
    bit m_bq;

    function automatic void model_reset();
        m_side = 0;
        m_run  = 0;
        m_err  = 1'b0;
        m_bq   = 1'b0;
    endfunction

    function automatic void model_edge(bit b, bit l, bit r);
        int want;
        m_bq = b;
        if (m_err || (l && r)) begin
            m_err  = 1'b1;
            m_side = 0;
            m_run  = 0;
        end else begin
            want = l ? 1 : (r ? 2 : 0);
            if (want == 0) begin
                m_side = 0;
                m_run  = 0;
            end else if (want == m_side) begin
                m_run = m_run + 1;
            end else begin
                m_side = want;
                m_run  = 1;
            end
        end
    endfunction

    // Expected vector ordered {error, l2, l1, l0, r2, r1, r0}.
    function automatic logic [6:0] model_expect();
        int         lit;
        logic [2:0] pat;
        logic [2:0] lft;
        logic [2:0] rgt;
        lit = m_run % 4;
        pat = 3'((1 << lit) - 1);
        lft = (m_side == 1) ? pat : {3{m_bq}};
        rgt = (m_side == 2) ? pat : {3{m_bq}};
        return {m_err, lft, rgt};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.error, bus.l2, bus.l1, bus.l0, bus.r2, bus.r1, bus.r0};
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit b, input bit l, input bit r);
        bus.brake = b;
        bus.left  = l;
        bus.right = r;
        @(posedge clka);
        model_edge(b, l, r);
        #1;
        check(tag, model_expect());
    endtask

    // Assert restart with random inputs; lamps must clear at once and stay dark.
    task automatic do_reset(input int cycles);
        bus.brake = 1'($urandom);
        bus.left  = 1'($urandom);
        bus.right = 1'($urandom);
        restart   = 1'b1;
        model_reset();
        #1;
        check("reset_async", 7'b0);
        repeat (cycles) @(posedge clka);
        #1;
        check("reset_hold", 7'b0);
        restart = 1'b0;
    endtask

    logic [2:0] sweep_tbl [4];
    int mode;
    bit rb;

    initial begin
        sweep_tbl[0] = 3'b001;
        sweep_tbl[1] = 3'b011;
        sweep_tbl[2] = 3'b111;
        sweep_tbl[3] = 3'b000;

        restart   = 1'b1;
        bus.brake = 1'b0;
        bus.left  = 1'b0;
        bus.right = 1'b0;
        model_reset();

        // Reset then idle.
        do_reset(2);
        step("idle", 0, 0, 0);
        check("idle_const", 7'b0);

        // Left sweep, then left with brake.
        for (int i = 0; i < 8; i++) begin
            step("left_sweep", 0, 1, 0);
            check("left_tbl", {1'b0, sweep_tbl[i % 4], 3'b000});
        end
        for (int i = 0; i < 4; i++) begin
            step("left_brake", 1, 1, 0);
            check("left_brake_tbl", {1'b0, sweep_tbl[i], 3'b111});
        end

        // Direction change straight from left to right restarts at phase 1.
        step("dir_change", 0, 1, 0);
        step("dir_change", 1, 0, 1);
        check("dir_change_tbl", {1'b0, 3'b111, 3'b001});

        // Right sweep after a restart pulse, then right with brake.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            step("right_sweep", 0, 0, 1);
            check("right_tbl", {1'b0, 3'b000, sweep_tbl[i % 4]});
        end
        for (int i = 0; i < 4; i++) begin
            step("right_brake", 1, 0, 1);
            check("right_brake_tbl", {1'b0, 3'b111, sweep_tbl[i]});
        end

        // Brake only.
        for (int i = 0; i < 3; i++) begin
            step("brake_only", 1, 0, 0);
            check("brake_only_tbl", 7'b0111111);
        end

        // Reset mid-sweep, then a fresh request restarts at phase 1.
        step("pre_mid", 0, 1, 0);
        step("pre_mid", 0, 1, 0);
        do_reset(1);
        step("post_mid", 0, 1, 0);
        check("post_mid_tbl", 7'b0001000);

        // Hazard: sticky error until restart.
        do_reset(1);
        step("hazard", 0, 1, 1);
        check("hazard_tbl", 7'b1000000);
        step("hazard", 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step("err_sticky", 0, 1, 0);
            check("err_sticky_tbl", 7'b1000000);
        end
        step("err_brake", 1, 0, 1);
        check("err_brake_tbl", 7'b1111111);
        do_reset(1);
        step("err_cleared", 0, 0, 0);
        check("err_cleared_tbl", 7'b0);
        step("hazard2", 0, 1, 1);
        check("hazard2_tbl", 7'b1000000);
        do_reset(1);

        // Randomized request sequences with held modes and occasional restart pulses.
        mode = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_reset($urandom_range(1, 2));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    mode = $urandom_range(0, 40);
                end
                rb = 1'($urandom);
                if (mode == 0)
                    step("rand", rb, 1, 1);
                else if (mode <= 15)
                    step("rand", rb, 1, 0);
                else if (mode <= 30)
                    step("rand", rb, 0, 1);
                else
                    step("rand", rb, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
